// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup in F is combinational; E-stage resolution detects mispredicts and trains the table.
module branch_target_predictor #(
  parameter int INDEX_W  = 6,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcF,
  output logic              pred_takenF,
  output logic [31:0]       pred_targetF,
  input  logic              resolve_validE,
  input  logic              stallE,
  input  logic [31:0]       pcE,
  input  logic              takenE,
  input  logic [31:0]       targetE,
  input  logic              pred_takenE,
  input  logic [31:0]       pred_targetE,
  output logic              mispredictE,
  output logic [31:0]       redirect_pcE,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(CNT_INIT);

  // Resolution handshake: a branch is consumed on a cycle where
  // resolve_validE=1 and stallE=0; while stallE=1 the same branch is
  // held with identical inputs and nothing is consumed.
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];
  logic [PERF_W-1:0]  r_perf_br;
  logic [PERF_W-1:0]  r_perf_mp;

  logic [INDEX_W-1:0] w_idxF;
  logic [TAG_W-1:0]   w_tagF;
  logic               w_hitF;
  logic [INDEX_W-1:0] w_idxE;
  logic [TAG_W-1:0]   w_tagE;
  logic               w_hitE;
  logic               w_fire;
  logic               w_unused_pc;

  assign w_unused_pc = ^{pcF[1:0], pcE[1:0]};

  assign w_idxF = pcF[INDEX_W+1:2];
  assign w_tagF = pcF[31:INDEX_W+2];
  assign w_hitF = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);

  assign pred_takenF  = w_hitF && r_cnt[w_idxF][CNT_W-1];
  assign pred_targetF = w_hitF ? r_target[w_idxF] : pcF + 32'd4;

  assign w_idxE = pcE[INDEX_W+1:2];
  assign w_tagE = pcE[31:INDEX_W+2];
  assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
  assign w_fire = resolve_validE && !stallE;

  assign mispredictE = w_fire && ((takenE != pred_takenE) ||
                                  (takenE && pred_takenE && (targetE != pred_targetE)));
  // Not-taken resumes past the delay slot, which is already in flight.
  assign redirect_pcE = takenE ? targetE : pcE + 32'd8;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fire && takenE && !w_hitE) begin
      r_valid[w_idxE] <= 1'b1;
    end
  end

  // Payload has no reset; it is only meaningful behind r_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_fire) begin
      if (takenE) begin
        r_target[w_idxE] <= targetE;
        if (!w_hitE) begin
          r_tag[w_idxE] <= w_tagE;
          r_cnt[w_idxE] <= CNT_ALLOC;
        end else if (r_cnt[w_idxE] != '1) begin
          r_cnt[w_idxE] <= r_cnt[w_idxE] + 1'b1;
        end
      end else if (w_hitE && (r_cnt[w_idxE] != '0)) begin
        r_cnt[w_idxE] <= r_cnt[w_idxE] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else if (w_fire) begin
      if (r_perf_br != '1) r_perf_br <= r_perf_br + 1'b1;
      if (mispredictE && (r_perf_mp != '1)) r_perf_mp <= r_perf_mp + 1'b1;
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mp;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: lookup, training, aliasing,
// target mispredicts, stall holding and reset-over-fire.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        pred_takenF;
  logic [31:0] pred_targetF;
  logic        resolve_validE;
  logic        stallE;
  logic [31:0] pcE;
  logic        takenE;
  logic [31:0] targetE;
  logic        pred_takenE;
  logic [31:0] pred_targetE;
  logic        mispredictE;
  logic [31:0] redirect_pcE;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_target_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (pcF),
    .pred_takenF      (pred_takenF),
    .pred_targetF     (pred_targetF),
    .resolve_validE   (resolve_validE),
    .stallE           (stallE),
    .pcE              (pcE),
    .takenE           (takenE),
    .targetE          (targetE),
    .pred_takenE      (pred_takenE),
    .pred_targetE     (pred_targetE),
    .mispredictE      (mispredictE),
    .redirect_pcE     (redirect_pcE),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a resolving branch and let combinational outputs settle
  task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    resolve_validE = 1'b1;
    pcE          = pc;
    takenE       = tk;
    targetE      = tgt;
    pred_takenE  = ptk;
    pred_targetE = ptgt;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
    pcF = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_takenF}, {31'd0, exp_tk});
    chk({tag, "_target"}, pred_targetF, exp_tgt);
  endtask

  task automatic perf(input string tag, input int br, input int mp);
    chk({tag, "_branches"}, perf_branches, br);
    chk({tag, "_mispredicts"}, perf_mispredicts, mp);
  endtask

  initial begin
    rst = 1'b1; pcF = 32'h0; resolve_validE = 1'b0; stallE = 1'b0;
    pcE = 32'h0; takenE = 1'b0; targetE = 32'h0; pred_takenE = 1'b0; pred_targetE = 32'h0;
    step();
    step();
    rst = 1'b0;

    // reset state
    lookup("reset_lookup", 32'hBFC00100, 1'b0, 32'hBFC00104);
    perf("reset", 0, 0);

    // allocate on taken miss; F sees pre-update entry in the same cycle
    drive(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b0, 32'hBFC00104);
    chk("alloc_mispredict", {31'd0, mispredictE}, 32'd1);
    chk("alloc_redirect", redirect_pcE, 32'hBFC00200);
    chk("alloc_no_bypass", {31'd0, pred_takenF}, 32'd0);
    step();
    resolve_validE = 1'b0;
    lookup("alloc_hit", 32'hBFC00100, 1'b1, 32'hBFC00200);
    perf("alloc", 1, 1);

    // not-taken twice: cnt 2->1->0
    drive(32'hBFC00100, 1'b0, 32'hBFC00200, 1'b1, 32'hBFC00200);
    chk("nt1_mispredict", {31'd0, mispredictE}, 32'd1);
    chk("nt1_redirect", redirect_pcE, 32'hBFC00108);
    step();
    resolve_validE = 1'b0;
    lookup("nt1_lookup", 32'hBFC00100, 1'b0, 32'hBFC00200);
    drive(32'hBFC00100, 1'b0, 32'hBFC00200, 1'b0, 32'hBFC00200);
    chk("nt2_mispredict", {31'd0, mispredictE}, 32'd0);
    step();
    resolve_validE = 1'b0;
    lookup("nt2_lookup", 32'hBFC00100, 1'b0, 32'hBFC00200);
    perf("nt2", 3, 2);

    // four taken: cnt 0->1->2->3->3
    drive(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b0, 32'hBFC00200);
    chk("t1_mispredict", {31'd0, mispredictE}, 32'd1);
    step();
    drive(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b0, 32'hBFC00200);
    chk("t2_mispredict", {31'd0, mispredictE}, 32'd1);
    step();
    drive(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b1, 32'hBFC00200);
    chk("t3_mispredict", {31'd0, mispredictE}, 32'd0);
    step();
    drive(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b1, 32'hBFC00200);
    chk("t4_mispredict", {31'd0, mispredictE}, 32'd0);
    step();
    resolve_validE = 1'b0;
    lookup("sat_lookup", 32'hBFC00100, 1'b1, 32'hBFC00200);
    // one not-taken from saturated 3 leaves 2 (still taken); a wrap would give 0
    drive(32'hBFC00100, 1'b0, 32'hBFC00200, 1'b1, 32'hBFC00200);
    step();
    resolve_validE = 1'b0;
    lookup("sat_nowrap", 32'hBFC00100, 1'b1, 32'hBFC00200);
    perf("sat", 8, 5);

    // alias replacement at index 4
    drive(32'h00000010, 1'b1, 32'h00000500, 1'b0, 32'h00000014);
    step();
    resolve_validE = 1'b0;
    lookup("alias_first", 32'h00000010, 1'b1, 32'h00000500);
    drive(32'h00000110, 1'b1, 32'h00000600, 1'b0, 32'h00000114);
    chk("alias_mispredict", {31'd0, mispredictE}, 32'd1);
    step();
    resolve_validE = 1'b0;
    lookup("alias_old_miss", 32'h00000010, 1'b0, 32'h00000014);
    lookup("alias_new_hit", 32'h00000110, 1'b1, 32'h00000600);
    perf("alias", 10, 7);

    // right direction, wrong target
    drive(32'h00000020, 1'b1, 32'h00000100, 1'b0, 32'h00000024);
    step();
    resolve_validE = 1'b0;
    lookup("tgt_before", 32'h00000020, 1'b1, 32'h00000100);
    drive(32'h00000020, 1'b1, 32'h00000180, 1'b1, 32'h00000100);
    chk("tgt_mispredict", {31'd0, mispredictE}, 32'd1);
    chk("tgt_redirect", redirect_pcE, 32'h00000180);
    step();
    resolve_validE = 1'b0;
    lookup("tgt_after", 32'h00000020, 1'b1, 32'h00000180);
    perf("tgt", 12, 9);

    // stall for 3 cycles, then release: exactly one update
    stallE = 1'b1;
    drive(32'h00000030, 1'b1, 32'h00000700, 1'b0, 32'h00000034);
    chk("stall_no_mispredict", {31'd0, mispredictE}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    perf("stall_held", 12, 9);
    lookup("stall_miss", 32'h00000030, 1'b0, 32'h00000034);
    stallE = 1'b0;
    #1;
    chk("release_mispredict", {31'd0, mispredictE}, 32'd1);
    step();
    resolve_validE = 1'b0;
    perf("release", 13, 10);
    lookup("release_hit", 32'h00000030, 1'b1, 32'h00000700);

    // reset together with fire: reset wins
    drive(32'h00000040, 1'b1, 32'h00000800, 1'b0, 32'h00000044);
    rst = 1'b1;
    step();
    rst = 1'b0;
    resolve_validE = 1'b0;
    perf("rst_fire", 0, 0);
    lookup("rst_fire_miss", 32'h00000040, 1'b0, 32'h00000044);
    lookup("rst_inval_a", 32'hBFC00100, 1'b0, 32'hBFC00104);
    lookup("rst_inval_b", 32'h00000110, 1'b0, 32'h00000114);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
